// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: widths, mem_control bit positions,
// access FSM state encodings and the default memory timeout.
package mem_wb_stage_pkg;

    localparam int DEFAULT_ISA_WIDTH           = 32;
    localparam int DEFAULT_REG_FILE_ADDR_WIDTH = 5;
    localparam int MEM_TIMEOUT_CYCLES          = 16;

    localparam int MEM_WRITE_BIT = 1;
    localparam int MEM_READ_BIT  = 0;

    typedef enum logic [0:0] {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_mem_access(input logic no_op, input logic [1:0] mem_control);
        return ~no_op & (mem_control != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the memory (slave).
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int ISA_WIDTH = DEFAULT_ISA_WIDTH
);

    logic                 req;
    logic                 we;
    logic [ISA_WIDTH-1:0] addr;
    logic [ISA_WIDTH-1:0] wdata;
    logic                 ready;
    logic [ISA_WIDTH-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );

endinterface

// File: rtl/mem_wb_stage_access_fsm.sv
// Memory access controller: tracks an outstanding request, raises the stall,
// and aborts with a sticky bus_error after TIMEOUT_CYCLES unanswered req cycles.
module mem_access_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic access,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic mem_stall,
    output logic timeout_hit,
    output logic bus_error
);

    localparam int CNT_W = (($clog2(TIMEOUT_CYCLES) + 1) > 8) ? ($clog2(TIMEOUT_CYCLES) + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state;
    logic [CNT_W-1:0] cnt;

    // cnt counts req cycles already spent, so the last allowed cycle is CNT_LAST
    assign timeout_hit = (state == MEM_ST_WAIT) && (cnt == CNT_LAST) && !dmem_ready;
    assign mem_stall   = access && !dmem_ready && !timeout_hit;
    assign dmem_req    = access && ((state == MEM_ST_IDLE) || (state == MEM_ST_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MEM_ST_IDLE;
            cnt       <= '0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                MEM_ST_IDLE: begin
                    if (access && !dmem_ready) begin
                        state <= MEM_ST_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                MEM_ST_WAIT: begin
                    if (dmem_ready) begin
                        state <= MEM_ST_IDLE;
                        cnt   <= '0;
                    end else if (timeout_hit) begin
                        state     <= MEM_ST_IDLE;
                        cnt       <= '0;
                        bus_error <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= MEM_ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM-stage access controller fused with the MEM/WB pipeline register.
// Optional build macro MEM_MISALIGN_CHECK_EN drops non-word-aligned accesses.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int ISA_WIDTH           = DEFAULT_ISA_WIDTH,
    parameter int REG_FILE_ADDR_WIDTH = DEFAULT_REG_FILE_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES      = MEM_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_no_op,
    input  logic                           mem_reg_write_enable,
    input  logic [1:0]                     mem_mem_control,
    input  logic [ISA_WIDTH-1:0]           mem_alu_result,
    input  logic [ISA_WIDTH-1:0]           mem_store_data,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] mem_dest_reg_idx,
    mem_wb_stage_if.master                 dmem,
    output logic                           mem_stall,
    output logic                           wb_no_op,
    output logic                           wb_reg_write_enable,
    output logic                           wb_mem_read,
    output logic [ISA_WIDTH-1:0]           wb_alu_result,
    output logic [ISA_WIDTH-1:0]           wb_mem_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0] wb_dest_reg_idx,
    output logic                           bus_error
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                           misalign_error
`endif
);

    logic is_write;
    logic is_read;
    logic raw_access;
    logic misaligned;
    logic access;
    logic timeout_hit;

    // Both control bits set is a write, so a read only counts without the write bit
    assign is_write   = mem_mem_control[MEM_WRITE_BIT];
    assign is_read    = mem_mem_control[MEM_READ_BIT] & ~is_write;
    assign raw_access = is_mem_access(mem_no_op, mem_mem_control);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = raw_access & (mem_alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign access = raw_access & ~misaligned;

    assign dmem.we    = is_write;
    assign dmem.addr  = mem_alu_result;
    assign dmem.wdata = mem_store_data;

    mem_access_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_access_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .access      (access),
        .dmem_ready  (dmem.ready),
        .dmem_req    (dmem.req),
        .mem_stall   (mem_stall),
        .timeout_hit (timeout_hit),
        .bus_error   (bus_error)
    );

    // Stalled, aborted or misaligned instructions leave a bubble so each one retires once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_no_op            <= 1'b0;
            wb_reg_write_enable <= 1'b0;
            wb_mem_read         <= 1'b0;
            wb_alu_result       <= '0;
            wb_mem_data         <= '0;
            wb_dest_reg_idx     <= '0;
        end else if (mem_stall || timeout_hit || misaligned) begin
            wb_no_op            <= 1'b1;
            wb_reg_write_enable <= 1'b0;
        end else begin
            wb_no_op            <= mem_no_op;
            wb_reg_write_enable <= mem_reg_write_enable & ~mem_no_op;
            wb_mem_read         <= is_read;
            wb_alu_result       <= mem_alu_result;
            wb_dest_reg_idx     <= mem_dest_reg_idx;
            if (access && is_read) begin
                wb_mem_data <= dmem.rdata;
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_error <= 1'b0;
        end else begin
            misalign_error <= misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (TIMEOUT_CYCLES = 4).
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_no_op;
    logic        mem_reg_write_enable;
    logic [1:0]  mem_mem_control;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_dest_reg_idx;
    logic        mem_stall;
    logic        wb_no_op;
    logic        wb_reg_write_enable;
    logic        wb_mem_read;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic [4:0]  wb_dest_reg_idx;
    logic        bus_error;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_error;
`endif

    int testsRun;
    int testsFailed;

    mem_wb_stage_if #(.ISA_WIDTH(32)) dmem_bus ();

    mem_wb_stage #(
        .ISA_WIDTH           (32),
        .REG_FILE_ADDR_WIDTH (5),
        .TIMEOUT_CYCLES      (4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mem_no_op            (mem_no_op),
        .mem_reg_write_enable (mem_reg_write_enable),
        .mem_mem_control      (mem_mem_control),
        .mem_alu_result       (mem_alu_result),
        .mem_store_data       (mem_store_data),
        .mem_dest_reg_idx     (mem_dest_reg_idx),
        .dmem                 (dmem_bus),
        .mem_stall            (mem_stall),
        .wb_no_op             (wb_no_op),
        .wb_reg_write_enable  (wb_reg_write_enable),
        .wb_mem_read          (wb_mem_read),
        .wb_alu_result        (wb_alu_result),
        .wb_mem_data          (wb_mem_data),
        .wb_dest_reg_idx      (wb_dest_reg_idx),
        .bus_error            (bus_error)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_error       (misalign_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        no_op;
        logic        rwe;
        logic [1:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic        ready;
        logic [31:0] rdata;
        logic        xStall;
        logic        xReq;
        logic        xWe;
        logic        xWbNoOp;
        logic        xWbRwe;
        logic        xWbMemRead;
        logic [31:0] xWbAlu;
        logic [31:0] xWbMemData;
        logic [4:0]  xWbDest;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic no_op, input logic rwe, input logic [1:0] ctrl,
                                 input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] dest,
                                 input logic ready, input logic [31:0] rdata);
        mem_no_op            = no_op;
        mem_reg_write_enable = rwe;
        mem_mem_control      = ctrl;
        mem_alu_result       = alu;
        mem_store_data       = sdata;
        mem_dest_reg_idx     = dest;
        dmem_bus.ready       = ready;
        dmem_bus.rdata       = rdata;
    endtask

    task automatic waitAfterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Directed single-instruction vectors; wb_mem_data holds across non-loads
        vecs[0] = '{1'b0, 1'b1, 2'b00, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5};
        vecs[1] = '{1'b0, 1'b1, 2'b01, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7};
        vecs[2] = '{1'b0, 1'b0, 2'b10, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1'b1, 32'h1111_1111,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 5'd0};
        vecs[3] = '{1'b0, 1'b0, 2'b11, 32'h0000_0300, 32'h0000_0055, 5'd1, 1'b1, 32'h2222_2222,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 5'd1};
        vecs[4] = '{1'b1, 1'b1, 2'b01, 32'h0000_0400, 32'h0, 5'd9, 1'b0, 32'h3333_3333,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 5'd9};
        vecs[5] = '{1'b0, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd31};

        waitAfterEdge();
        waitAfterEdge();
        checkOutput("reset wb_no_op", wb_no_op, 0);
        checkOutput("reset wb_rwe", wb_reg_write_enable, 0);
        checkOutput("reset wb_alu", wb_alu_result, 0);
        checkOutput("reset wb_mem_data", wb_mem_data, 0);
        checkOutput("reset bus_error", bus_error, 0);
        checkOutput("reset stall", mem_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].no_op, vecs[i].rwe, vecs[i].ctrl, vecs[i].alu,
                          vecs[i].sdata, vecs[i].dest, vecs[i].ready, vecs[i].rdata);
            #1;
            checkOutput($sformatf("v%0d stall", i), mem_stall, vecs[i].xStall);
            checkOutput($sformatf("v%0d req", i), dmem_bus.req, vecs[i].xReq);
            checkOutput($sformatf("v%0d we", i), dmem_bus.we, vecs[i].xWe);
            checkOutput($sformatf("v%0d addr", i), dmem_bus.addr, vecs[i].alu);
            checkOutput($sformatf("v%0d wdata", i), dmem_bus.wdata, vecs[i].sdata);
            waitAfterEdge();
            checkOutput($sformatf("v%0d wb_no_op", i), wb_no_op, vecs[i].xWbNoOp);
            checkOutput($sformatf("v%0d wb_rwe", i), wb_reg_write_enable, vecs[i].xWbRwe);
            checkOutput($sformatf("v%0d wb_mem_read", i), wb_mem_read, vecs[i].xWbMemRead);
            checkOutput($sformatf("v%0d wb_alu", i), wb_alu_result, vecs[i].xWbAlu);
            checkOutput($sformatf("v%0d wb_mem_data", i), wb_mem_data, vecs[i].xWbMemData);
            checkOutput($sformatf("v%0d wb_dest", i), wb_dest_reg_idx, vecs[i].xWbDest);
        end

        // Load whose ready arrives on the fourth cycle: three bubbles, one write-back
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_0500, 32'h0, 5'd3, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checkOutput($sformatf("slow load stall c%0d", k), mem_stall, 1);
            checkOutput($sformatf("slow load req c%0d", k), dmem_bus.req, 1);
            waitAfterEdge();
            checkOutput($sformatf("slow load bubble c%0d", k), wb_no_op, 1);
            checkOutput($sformatf("slow load rwe c%0d", k), wb_reg_write_enable, 0);
            checkOutput($sformatf("slow load alu hold c%0d", k), wb_alu_result, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        dmem_bus.ready = 1'b1;
        dmem_bus.rdata = 32'hA5A5_A5A5;
        #1;
        checkOutput("slow load stall on ready", mem_stall, 0);
        waitAfterEdge();
        checkOutput("slow load wb_no_op", wb_no_op, 0);
        checkOutput("slow load wb_rwe", wb_reg_write_enable, 1);
        checkOutput("slow load wb_mem_read", wb_mem_read, 1);
        checkOutput("slow load wb_mem_data", wb_mem_data, 32'hA5A5_A5A5);
        checkOutput("slow load wb_alu", wb_alu_result, 32'h0000_0500);
        checkOutput("slow load wb_dest", wb_dest_reg_idx, 3);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0000_0700, 32'h0, 5'd2, 1'b0, 32'h0);
        waitAfterEdge();
        checkOutput("after load wb_mem_read", wb_mem_read, 0);
        checkOutput("after load wb_mem_data hold", wb_mem_data, 32'hA5A5_A5A5);
        checkOutput("after load wb_alu", wb_alu_result, 32'h0000_0700);

        // Store never answered: req for exactly 4 cycles, stall for 3, then sticky bus_error
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h0000_0600, 32'h1234_5678, 5'd0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checkOutput($sformatf("timeout req c%0d", k), dmem_bus.req, 1);
            checkOutput($sformatf("timeout stall c%0d", k), mem_stall, (k < 3) ? 1 : 0);
            waitAfterEdge();
            checkOutput($sformatf("timeout bubble c%0d", k), wb_no_op, 1);
            checkOutput($sformatf("timeout bus_error c%0d", k), bus_error, (k == 3) ? 1 : 0);
        end
        checkOutput("timeout wb_alu hold", wb_alu_result, 32'h0000_0700);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("post timeout req", dmem_bus.req, 0);
        waitAfterEdge();
        waitAfterEdge();
        checkOutput("bus_error sticky", bus_error, 1);

        // Asynchronous reset while a load is waiting
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_0800, 32'h0, 5'd6, 1'b0, 32'h0);
        waitAfterEdge();
        checkOutput("pre-reset stall", mem_stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset bus_error", bus_error, 0);
        checkOutput("async reset wb_no_op", wb_no_op, 0);
        checkOutput("async reset wb_rwe", wb_reg_write_enable, 0);
        checkOutput("async reset wb_alu", wb_alu_result, 0);
        checkOutput("async reset wb_mem_data", wb_mem_data, 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("reset req cleared", dmem_bus.req, 0);
        checkOutput("reset stall cleared", mem_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_0900, 32'h0, 5'd4, 1'b1, 32'h0BAD_F00D);
        #1;
        checkOutput("post-reset load stall", mem_stall, 0);
        waitAfterEdge();
        checkOutput("post-reset load wb_mem_data", wb_mem_data, 32'h0BAD_F00D);
        checkOutput("post-reset load wb_mem_read", wb_mem_read, 1);
        checkOutput("post-reset load wb_dest", wb_dest_reg_idx, 4);
        checkOutput("post-reset bus_error", bus_error, 0);

`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_1002, 32'h0, 5'd8, 1'b1, 32'h7777_7777);
        #1;
        checkOutput("misalign req", dmem_bus.req, 0);
        checkOutput("misalign stall", mem_stall, 0);
        waitAfterEdge();
        checkOutput("misalign error pulse", misalign_error, 1);
        checkOutput("misalign bubble", wb_no_op, 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0000_0004, 32'h0, 5'd8, 1'b0, 32'h0);
        waitAfterEdge();
        checkOutput("misalign error clears", misalign_error, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
